// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: requester IDs carried in the
// response ID FIFO and the selection-state encoding.
package mem_port_arbiter_pkg;

   // Requester IDs stored per accepted request and used to route responses.
   localparam logic REQ_ID_IF = 1'b0;
   localparam logic REQ_ID_D  = 1'b1;

   // StFree: selection is recomputed every cycle.
   // StHeld: a presented request was not accepted and stays selected until granted.
   typedef enum logic {
      StFree,
      StHeld
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch (if_*), load/store (d_*) and downstream memory (mem_*)
// handshake signals around the memory-port arbiter.
//   master : environment view (core stages drive requests, memory drives gnt/rvalid)
//   slave  : arbiter view
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // fetch port
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_W-1:0]     if_rdata;
   // load/store port
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_wstrb;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_W-1:0]     d_rdata;
   // downstream memory port
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_addr, d_wdata, d_wstrb,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/mem_port_arbiter_resp_id_fifo.sv
// 1-bit wide FIFO holding the requester ID of every accepted-but-unanswered
// memory request, oldest at the head.
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : enqueue din
//   pop        : dequeue head (ignored when empty)
//   dout       : head entry
//   empty/full : occupancy flags
//   count      : number of stored entries
module mem_port_arbiter_resp_id_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       din,
   output logic                       dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A push while full is accepted only alongside a pop, which frees the slot
   // the write pointer is sitting on.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one in-order pipelined memory port between instruction fetch (IF)
// and the execute-stage load/store port (D). D has fixed priority; IF gets
// priority once it has been denied STARVE_LIM consecutive cycles. Responses
// are routed back through an ID FIFO with no added latency.
//   clk, rst       : clock, asynchronous active-high reset
//   bus            : if_*/d_* requester ports and mem_* downstream port (slave view)
//   outstanding    : accepted-but-unanswered request count
//   err_unexp_rsp  : sticky, a response arrived with nothing in flight
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_OUT    = 4,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   mem_port_arbiter_if.slave            bus,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         err_unexp_rsp
);

   localparam int unsigned SC_W   = $clog2(STARVE_LIM + 1);
   localparam int unsigned STRB_W = DATA_W / 8;

   arb_state_e      state_q, state_d;
   logic            hold_sel_q, hold_sel_d;
   logic [SC_W-1:0] starve_q, starve_d;
   logic            err_q;

   logic sel, sel_req, issue, grant, starved;
   logic fifo_full, fifo_empty, head_id, rsp_pop;

   assign starved = (starve_q >= SC_W'(STARVE_LIM));

   // Selection, issue and next state
   always_comb begin
      state_d    = state_q;
      hold_sel_d = hold_sel_q;
      sel        = REQ_ID_D;

      unique case (state_q)
         StFree: begin
            if (starved && bus.if_req) begin
               sel = REQ_ID_IF;
            end else if (bus.d_req) begin
               sel = REQ_ID_D;
            end else if (bus.if_req) begin
               sel = REQ_ID_IF;
            end
         end
         StHeld:  sel = hold_sel_q;
         default: sel = REQ_ID_D;
      endcase

      sel_req = (sel == REQ_ID_IF) ? bus.if_req : bus.d_req;
      // FIFO full is equivalent to outstanding == MAX_OUT.
      issue   = sel_req && !fifo_full && !rst;
      grant   = issue && bus.mem_gnt;

      unique case (state_q)
         StFree: begin
            if (issue && !bus.mem_gnt) begin
               state_d    = StHeld;
               hold_sel_d = sel;
            end
         end
         StHeld: begin
            if (bus.mem_gnt) begin
               state_d = StFree;
            end
         end
         default: state_d = StFree;
      endcase
   end

   // Downstream command mux; fetches are always reads with no write data.
   always_comb begin
      bus.mem_req   = issue;
      bus.if_gnt    = grant && (sel == REQ_ID_IF);
      bus.d_gnt     = grant && (sel == REQ_ID_D);
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
      bus.mem_wstrb = {STRB_W{1'b0}};
      if (sel == REQ_ID_D) begin
         bus.mem_we    = bus.d_we;
         bus.mem_addr  = bus.d_addr;
         bus.mem_wdata = bus.d_wdata;
         bus.mem_wstrb = bus.d_wstrb;
      end else begin
         bus.mem_addr  = bus.if_addr;
      end
   end

   // Consecutive cycles IF has been kept waiting, saturating at STARVE_LIM.
   always_comb begin
      starve_d = '0;
      if (bus.if_req && !(grant && (sel == REQ_ID_IF))) begin
         starve_d = starved ? starve_q : starve_q + SC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StFree;
         hold_sel_q <= REQ_ID_IF;
         starve_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_sel_q <= hold_sel_d;
         starve_q   <= starve_d;
         if (bus.mem_rvalid && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   // Response routing: a response with nothing in flight is dropped.
   assign rsp_pop       = bus.mem_rvalid && !fifo_empty && !rst;
   assign err_unexp_rsp = err_q;

   always_comb begin
      bus.if_rvalid = rsp_pop && (head_id == REQ_ID_IF);
      bus.d_rvalid  = rsp_pop && (head_id == REQ_ID_D);
      bus.if_rdata  = bus.mem_rdata;
      bus.d_rdata   = bus.mem_rdata;
   end

   mem_port_arbiter_resp_id_fifo #(
      .DEPTH (MAX_OUT)
   ) u_resp_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .pop   (rsp_pop),
      .din   (sel),
      .dout  (head_id),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (outstanding)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed boundary scenarios, then randomized
// traffic with a scoreboard fed from the request drivers and a monitor that
// checks every if/d response in order.
module tb_mem_port_arbiter;

   logic       clk;
   logic       rst;
   logic [2:0] outstanding;
   logic       err_unexp_rsp;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MAX_OUT    (4),
      .STARVE_LIM (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .outstanding   (outstanding),
      .err_unexp_rsp (err_unexp_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        st;
      logic [31:0] data;
   } dexp_t;

   logic [31:0] if_exp[$];
   dexp_t       d_exp[$];
   logic [31:0] pend[$];
   logic [31:0] mem_model[8];
   logic [31:0] dref[8];
   bit          mon_en = 1'b0;
   logic [31:0] mon_e;
   dexp_t       mon_de;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.d_req      = 1'b0;
      bus.d_we       = 1'b0;
      bus.d_addr     = '0;
      bus.d_wdata    = '0;
      bus.d_wstrb    = '0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   task automatic do_reset();
      step();
      idle();
      rst = 1'b1;
      samp();
      step();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rom(input logic [2:0] i);
      return 32'hC0DE_0100 + 32'(i) * 32'h0000_0011;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      end
      return r;
   endfunction

   // Response monitor: every if/d response must match the oldest expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.if_rvalid) begin
            if (if_exp.size() == 0) begin
               chk("if_rsp_extra", 32'd1, 32'd0);
            end else begin
               mon_e = if_exp.pop_front();
               chk("if_rdata", bus.if_rdata, mon_e);
            end
         end
         if (bus.d_rvalid) begin
            if (d_exp.size() == 0) begin
               chk("d_rsp_extra", 32'd1, 32'd0);
            end else begin
               mon_de = d_exp.pop_front();
               if (!mon_de.st) chk("d_rdata", bus.d_rdata, mon_de.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit          if_act, d_act, running, rv_drv, drained;
      logic [2:0]  idx;
      logic [31:0] wd;
      logic [3:0]  ws;

      rst = 1'b1;
      idle();
      do_reset();

      // Reset state
      samp();
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_err", 32'(err_unexp_rsp), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);

      // Starvation: D wins 4 cycles, IF on the 5th; responses one cycle later
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         step();
         bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
         bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8000_0000;
         bus.mem_gnt = 1'b1;
         bus.mem_rvalid = (c >= 2); bus.mem_rdata = 32'h100 + 32'(c);
         samp();
         chk("starve_d_gnt", 32'(bus.d_gnt), 32'(c <= 4));
         chk("starve_if_gnt", 32'(bus.if_gnt), 32'(c == 5));
         if (c >= 2) begin
            chk("starve_d_rvalid", 32'(bus.d_rvalid), 32'd1);
            chk("starve_d_rdata", bus.d_rdata, 32'h100 + 32'(c));
         end
      end
      step();
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h200;
      samp();
      chk("starve_if_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("starve_if_rdata", bus.if_rdata, 32'h200);
      chk("starve_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("starve_outstanding", 32'(outstanding), 32'd1);

      // Held D request is not stolen by a starved IF
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         step();
         bus.d_req = 1'b1; bus.d_addr = 32'h8000_0010; bus.d_we = 1'b0;
         bus.if_req = (c >= 2); bus.if_addr = 32'h0000_1004;
         bus.mem_gnt = (c >= 7);
         samp();
         if (c <= 6) begin
            chk("held_addr", bus.mem_addr, 32'h8000_0010);
            chk("held_no_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
         end else if (c == 7) begin
            chk("held_d_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'b01);
         end else begin
            chk("held_then_if_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'b10);
            chk("held_then_if_addr", bus.mem_addr, 32'h0000_1004);
         end
      end

      // Held IF request is not switched to a later D request
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         step();
         bus.if_req = (c <= 3); bus.if_addr = 32'h0000_1008;
         bus.d_req = (c >= 2); bus.d_addr = 32'h8000_0020; bus.d_we = 1'b0;
         bus.mem_gnt = (c >= 3);
         samp();
         if (c <= 2) chk("hold_if_addr", bus.mem_addr, 32'h0000_1008);
         if (c == 3) chk("hold_if_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'b10);
         if (c == 4) chk("hold_if_then_d", 32'({bus.if_gnt, bus.d_gnt}), 32'b01);
      end

      // Outstanding limit, oldest-first routing, same-cycle grant + response
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         step();
         bus.mem_gnt = 1'b1;
         bus.if_req = (c == 1); bus.if_addr = 32'h0000_100C;
         bus.d_req = (c >= 2 && c <= 9); bus.d_addr = 32'h8000_0004; bus.d_we = 1'b0;
         bus.mem_rvalid = (c == 6 || c == 8 || c == 9);
         bus.mem_rdata = 32'h0000_0A00 + 32'(c);
         samp();
         unique case (c)
            1: chk("lim_if_gnt", 32'(bus.if_gnt), 32'd1);
            2, 3, 4: chk("lim_d_gnt", 32'(bus.d_gnt), 32'd1);
            5: begin
               chk("lim_full_mem_req", 32'(bus.mem_req), 32'd0);
               chk("lim_full_d_gnt", 32'(bus.d_gnt), 32'd0);
               chk("lim_full_outstanding", 32'(outstanding), 32'd4);
            end
            6: begin
               chk("lim_oldest_if_rvalid", 32'(bus.if_rvalid), 32'd1);
               chk("lim_oldest_if_rdata", bus.if_rdata, 32'h0000_0A06);
               chk("lim_oldest_no_d", 32'({bus.d_rvalid, bus.d_gnt}), 32'd0);
            end
            7: begin
               chk("lim_reissue_outstanding", 32'(outstanding), 32'd3);
               chk("lim_reissue_d_gnt", 32'(bus.d_gnt), 32'd1);
            end
            8: chk("lim_full_rsp", 32'({bus.d_rvalid, bus.d_gnt}), 32'b10);
            9: begin
               chk("lim_same_cycle_outstanding", 32'(outstanding), 32'd3);
               chk("lim_same_cycle_gnt_rsp", 32'({bus.d_rvalid, bus.d_gnt}), 32'b11);
            end
            default: chk("lim_after_same_cycle", 32'(outstanding), 32'd3);
         endcase
      end

      // Store command pass-through; IF commands carry no write data
      do_reset();
      step();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_0008;
      bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011; bus.mem_gnt = 1'b1;
      samp();
      chk("st_gnt", 32'(bus.d_gnt), 32'd1);
      chk("st_we", 32'(bus.mem_we), 32'd1);
      chk("st_wstrb", 32'(bus.mem_wstrb), 32'h3);
      chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("st_addr", bus.mem_addr, 32'h8000_0008);
      step();
      bus.d_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_1010;
      samp();
      chk("st_rsp", 32'({bus.if_rvalid, bus.d_rvalid}), 32'b01);
      chk("if_cmd_zero", 32'({bus.mem_we, bus.mem_wstrb}), 32'd0);
      chk("if_wdata_zero", bus.mem_wdata, 32'd0);
      step();
      bus.if_req = 1'b0; bus.mem_rvalid = 1'b0;
      samp();
      chk("st_single_rsp", 32'(bus.d_rvalid), 32'd0);

      // Reset mid-traffic, then responses to pre-reset requests
      do_reset();
      for (int c = 1; c <= 2; c++) begin
         step();
         bus.mem_gnt = 1'b1;
         bus.if_req = (c == 1); bus.if_addr = 32'h0000_1000;
         bus.d_req = (c == 2); bus.d_addr = 32'h8000_0000;
         samp();
      end
      chk("pre_rst_outstanding", 32'(outstanding), 32'd1);
      step();
      rst = 1'b1;
      bus.if_req = 1'b1; bus.d_req = 1'b1; bus.mem_gnt = 1'b1;
      samp();
      chk("in_rst_gnts", 32'({bus.mem_req, bus.if_gnt, bus.d_gnt}), 32'd0);
      chk("in_rst_outstanding", 32'(outstanding), 32'd0);
      step();
      rst = 1'b0;
      idle();
      for (int c = 1; c <= 4; c++) begin
         step();
         bus.mem_rvalid = (c <= 2); bus.mem_rdata = 32'h5555_0000;
         samp();
         chk("unexp_no_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
         chk("unexp_err", 32'(err_unexp_rsp), 32'(c >= 2));
      end
      do_reset();
      samp();
      chk("err_cleared", 32'(err_unexp_rsp), 32'd0);

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 8; i++) begin
         mem_model[i] = 32'h5000_0000 + 32'(i);
         dref[i]      = 32'h5000_0000 + 32'(i);
      end
      if_act = 1'b0; d_act = 1'b0; running = 1'b1; drained = 1'b0;
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 3300 && !drained; cyc++) begin
         if (cyc == 3000) running = 1'b0;
         step();
         bus.mem_gnt = running ? ($urandom_range(0, 3) != 0) : 1'b1;
         rv_drv = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
         bus.mem_rvalid = rv_drv;
         bus.mem_rdata  = rv_drv ? pend[0] : $urandom();
         if (!if_act) begin
            bus.if_req = 1'b0;
            if (running && $urandom_range(0, 2) == 0) begin
               idx = 3'($urandom_range(0, 7));
               bus.if_req  = 1'b1;
               bus.if_addr = 32'h0000_1000 + 32'(idx) * 4;
               if_exp.push_back(rom(idx));
               if_act = 1'b1;
            end
         end
         if (!d_act) begin
            bus.d_req = 1'b0;
            if (running && $urandom_range(0, 2) == 0) begin
               idx = 3'($urandom_range(0, 7));
               wd  = $urandom();
               ws  = 4'($urandom_range(0, 15));
               bus.d_req   = 1'b1;
               bus.d_addr  = 32'h8000_0000 + 32'(idx) * 4;
               bus.d_we    = ($urandom_range(0, 1) == 1);
               bus.d_wdata = wd;
               bus.d_wstrb = ws;
               if (bus.d_we) begin
                  dref[idx] = merge(dref[idx], wd, ws);
                  d_exp.push_back('{st: 1'b1, data: 32'd0});
               end else begin
                  d_exp.push_back('{st: 1'b0, data: dref[idx]});
               end
               d_act = 1'b1;
            end
         end
         samp();
         chk("rnd_outstanding", 32'(outstanding), 32'(pend.size()));
         chk("rnd_gnt_exclusive", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
         if (rv_drv) void'(pend.pop_front());
         if (bus.mem_req && bus.mem_gnt) begin
            if (bus.if_gnt) begin
               chk("rnd_if_cmd_zero", 32'({bus.mem_we, bus.mem_wstrb}), 32'd0);
               chk("rnd_if_wdata_zero", bus.mem_wdata, 32'd0);
            end
            idx = bus.mem_addr[4:2];
            if (bus.mem_we) begin
               mem_model[idx] = merge(mem_model[idx], bus.mem_wdata, bus.mem_wstrb);
               pend.push_back(32'd0);
            end else begin
               pend.push_back(bus.mem_addr[31] ? mem_model[idx] : rom(idx));
            end
         end
         if (bus.if_gnt) if_act = 1'b0;
         if (bus.d_gnt) d_act = 1'b0;
         if (!running && !if_act && !d_act && pend.size() == 0) drained = 1'b1;
      end
      chk("rnd_drained", 32'(drained), 32'd1);
      step();
      idle();
      samp();
      chk("rnd_if_all_answered", 32'(if_exp.size()), 32'd0);
      chk("rnd_d_all_answered", 32'(d_exp.size()), 32'd0);
      chk("rnd_no_err", 32'(err_unexp_rsp), 32'd0);
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
